// File: rtl/axi_mm_ostd_pkg.sv
// Shared types and constants for the AXI-MM outstanding-transaction controller.
package axi_mm_ostd_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        QUIESCED = 2'd2
    } ostd_state_e;

    localparam int ERR_RD_UFL = 0;
    localparam int ERR_B_UFL  = 1;
    localparam int ERR_WDOG   = 2;

    // A runtime limit of 0, or one above the hard cap, selects the hard cap.
    function automatic int eff_limit(input int cfg, input int max_ostd);
        return (cfg == 0 || cfg > max_ostd) ? max_ostd : cfg;
    endfunction

endpackage

// File: rtl/axi_mm_ostd_cnt.sv
// Saturating up/down outstanding counter with limit compare and underflow flag.
module axi_mm_ostd_cnt #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         below_lim,
    output logic         ufl
);

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        below_lim = (cnt < limit);
        ufl       = dec && !inc && (cnt == '0);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != W'(MAX)) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/axi_mm_master_ostd_ctrl.sv
// Outstanding-transaction throttle and drain/quiesce handshake for an AXI-MM master link.
// Optional watchdog enabled by defining AXI_MM_OSTD_WDOG_EN.
module axi_mm_master_ostd_ctrl
    import axi_mm_ostd_pkg::*;
#(
    parameter int MAX_RD_OSTD = 8,
    parameter int MAX_WR_OSTD = 8,
    parameter int WDOG_CYCLES = 1024,
    localparam int CW = $clog2(((MAX_RD_OSTD > MAX_WR_OSTD) ? MAX_RD_OSTD : MAX_WR_OSTD) + 1)
) (
    input  logic          clk_wr,
    input  logic          rst_wr_n,
    input  logic [CW-1:0] cfg_rd_limit,
    input  logic [CW-1:0] cfg_wr_limit,
    input  logic          user_arvalid,
    output logic          user_arready,
    output logic          link_arvalid,
    input  logic          link_arready,
    input  logic          user_awvalid,
    output logic          user_awready,
    output logic          link_awvalid,
    input  logic          link_awready,
    input  logic          user_wvalid,
    input  logic          user_wlast,
    output logic          user_wready,
    output logic          link_wvalid,
    input  logic          link_wready,
    input  logic          link_rvalid,
    input  logic          link_rlast,
    output logic          link_rready,
    output logic          user_rvalid,
    input  logic          user_rready,
    input  logic          link_bvalid,
    output logic          link_bready,
    output logic          user_bvalid,
    input  logic          user_bready,
    input  logic          drain_req,
    output logic          drain_ack,
    output logic [CW-1:0] rd_ostd_cnt,
    output logic [CW-1:0] wr_ostd_cnt,
    output logic [2:0]    err_status
);

    ostd_state_e   state;
    logic [CW-1:0] rd_lim, wr_lim, wcred;
    logic          rd_below, wr_below, wcred_below;
    logic          rd_ufl, wr_ufl, wcred_ufl;
    logic          ar_ok, aw_ok, w_ok;
    logic          ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;
    logic          wdog_hit;
    logic [2:0]    err_set;
    logic          unused_ok;

    always_comb begin
        rd_lim = CW'(eff_limit(int'(cfg_rd_limit), MAX_RD_OSTD));
        wr_lim = CW'(eff_limit(int'(cfg_wr_limit), MAX_WR_OSTD));

        ar_ok = (state == RUN) && rd_below;
        aw_ok = (state == RUN) && wr_below;
        w_ok  = (wcred != '0);

        link_arvalid = user_arvalid & ar_ok;
        user_arready = link_arready & ar_ok;
        link_awvalid = user_awvalid & aw_ok;
        user_awready = link_awready & aw_ok;
        link_wvalid  = user_wvalid & w_ok;
        user_wready  = link_wready & w_ok;

        user_rvalid = link_rvalid;
        link_rready = user_rready;
        user_bvalid = link_bvalid;
        link_bready = user_bready;

        ar_hs     = link_arvalid & link_arready;
        aw_hs     = link_awvalid & link_awready;
        w_last_hs = link_wvalid & link_wready & user_wlast;
        r_last_hs = link_rvalid & user_rready & link_rlast;
        b_hs      = link_bvalid & user_bready;

        err_set             = '0;
        err_set[ERR_RD_UFL] = rd_ufl;
        err_set[ERR_B_UFL]  = wr_ufl;
        err_set[ERR_WDOG]   = wdog_hit;
    end

    axi_mm_ostd_cnt #(.W(CW), .MAX(MAX_RD_OSTD)) u_rd_cnt (
        .clk(clk_wr), .rst_n(rst_wr_n), .inc(ar_hs), .dec(r_last_hs), .limit(rd_lim),
        .cnt(rd_ostd_cnt), .below_lim(rd_below), .ufl(rd_ufl)
    );

    axi_mm_ostd_cnt #(.W(CW), .MAX(MAX_WR_OSTD)) u_wr_cnt (
        .clk(clk_wr), .rst_n(rst_wr_n), .inc(aw_hs), .dec(b_hs), .limit(wr_lim),
        .cnt(wr_ostd_cnt), .below_lim(wr_below), .ufl(wr_ufl)
    );

    // Write credits never exceed wr_ostd_cnt, so the write cap bounds them too.
    axi_mm_ostd_cnt #(.W(CW), .MAX(MAX_WR_OSTD)) u_wcred (
        .clk(clk_wr), .rst_n(rst_wr_n), .inc(aw_hs), .dec(w_last_hs), .limit(CW'(MAX_WR_OSTD)),
        .cnt(wcred), .below_lim(wcred_below), .ufl(wcred_ufl)
    );

`ifdef AXI_MM_OSTD_WDOG_EN
    logic [31:0] idle_cnt;

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            idle_cnt <= '0;
        end else if (r_last_hs || b_hs || (rd_ostd_cnt == '0 && wr_ostd_cnt == '0)) begin
            idle_cnt <= '0;
        end else if (idle_cnt != 32'hFFFF_FFFF) begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign wdog_hit  = (idle_cnt >= 32'(WDOG_CYCLES));
    assign unused_ok = &{1'b0, wcred_below, wcred_ufl};
`else
    assign wdog_hit  = 1'b0;
    assign unused_ok = &{1'b0, wcred_below, wcred_ufl, (32'(WDOG_CYCLES) != 32'd0)};
`endif

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            err_status <= '0;
        end else begin
            err_status <= err_status | err_set;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state     <= RUN;
            drain_ack <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (drain_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state <= RUN;
                    end else if (rd_ostd_cnt == '0 && wr_ostd_cnt == '0 && wcred == '0) begin
                        state     <= QUIESCED;
                        drain_ack <= 1'b1;
                    end
                end
                QUIESCED: begin
                    if (!drain_req) begin
                        state     <= RUN;
                        drain_ack <= 1'b0;
                    end
                end
                default: begin
                    state     <= RUN;
                    drain_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mm_master_ostd_ctrl.sv
// Directed bench: combinational gating table plus multi-cycle throttle, credit and drain sequences.
module tb_axi_mm_master_ostd_ctrl;

    localparam int CW = 4;

    logic          clk_wr = 1'b0;
    logic          rst_wr_n = 1'b0;
    logic [CW-1:0] cfg_rd_limit = '0, cfg_wr_limit = '0;
    logic user_arvalid = 0, user_arready, link_arvalid, link_arready = 0;
    logic user_awvalid = 0, user_awready, link_awvalid, link_awready = 0;
    logic user_wvalid = 0, user_wlast = 0, user_wready, link_wvalid, link_wready = 0;
    logic link_rvalid = 0, link_rlast = 0, link_rready, user_rvalid, user_rready = 0;
    logic link_bvalid = 0, link_bready, user_bvalid, user_bready = 0;
    logic          drain_req = 0, drain_ack;
    logic [CW-1:0] rd_ostd_cnt, wr_ostd_cnt;
    logic [2:0]    err_status;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_wr = ~clk_wr;

    axi_mm_master_ostd_ctrl dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
        .cfg_rd_limit(cfg_rd_limit), .cfg_wr_limit(cfg_wr_limit),
        .user_arvalid(user_arvalid), .user_arready(user_arready),
        .link_arvalid(link_arvalid), .link_arready(link_arready),
        .user_awvalid(user_awvalid), .user_awready(user_awready),
        .link_awvalid(link_awvalid), .link_awready(link_awready),
        .user_wvalid(user_wvalid), .user_wlast(user_wlast), .user_wready(user_wready),
        .link_wvalid(link_wvalid), .link_wready(link_wready),
        .link_rvalid(link_rvalid), .link_rlast(link_rlast), .link_rready(link_rready),
        .user_rvalid(user_rvalid), .user_rready(user_rready),
        .link_bvalid(link_bvalid), .link_bready(link_bready),
        .user_bvalid(user_bvalid), .user_bready(user_bready),
        .drain_req(drain_req), .drain_ack(drain_ack),
        .rd_ostd_cnt(rd_ostd_cnt), .wr_ostd_cnt(wr_ostd_cnt),
        .err_status(err_status)
    );

    // in  = {arvalid, link_arready, awvalid, link_awready, wvalid, link_wready, link_rvalid, user_rready, link_bvalid, user_bready}
    // exp = {link_arvalid, user_arready, link_awvalid, user_awready, link_wvalid, user_wready, user_rvalid, link_rready, user_bvalid, link_bready}
    typedef struct {
        string      name;
        logic [9:0] in;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic apply(input logic [9:0] v);
        {user_arvalid, link_arready, user_awvalid, link_awready, user_wvalid,
         link_wready, link_rvalid, user_rready, link_bvalid, user_bready} = v;
    endtask

    function automatic logic [9:0] outs();
        return {link_arvalid, user_arready, link_awvalid, user_awready, link_wvalid,
                user_wready, user_rvalid, link_rready, user_bvalid, link_bready};
    endfunction

    initial begin
        // Idle, empty, RUN: AR/AW pass, W blocked (no credit), R/B straight through.
        vecs[0] = '{"idle",      10'b00_00_00_00_00, 10'b00_00_00_00_00};
        vecs[1] = '{"ar_pass",   10'b11_00_00_00_00, 10'b11_00_00_00_00};
        vecs[2] = '{"aw_pass",   10'b00_10_00_00_00, 10'b00_10_00_00_00};
        vecs[3] = '{"w_blocked", 10'b00_00_11_00_00, 10'b00_00_00_00_00};
        vecs[4] = '{"rb_pass",   10'b00_00_00_10_01, 10'b00_00_00_10_01};
        vecs[5] = '{"all_on",    10'b01_01_11_11_11, 10'b01_01_00_11_11};

        #12 rst_wr_n = 1'b1;
        nxt();
        check("rst_rd_cnt", 32'(rd_ostd_cnt), 0);
        check("rst_wr_cnt", 32'(wr_ostd_cnt), 0);
        check("rst_drain_ack", 32'(drain_ack), 0);
        check("rst_err", 32'(err_status), 0);

        // Vectors are removed before the next edge so nothing is committed.
        for (int i = 0; i < 6; i++) begin
            apply(vecs[i].in);
            #1;
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            apply('0);
            nxt();
        end

        // Read limit 2: two ARs issue, third stalls until the first R-last.
        cfg_rd_limit = 4'd2;
        user_arvalid = 1; link_arready = 1;
        #1 check("ar0_issue", 32'(link_arvalid), 1);
        nxt();
        check("ar1_issue", 32'(link_arvalid), 1);
        check("rd_cnt_1", 32'(rd_ostd_cnt), 1);
        nxt();
        check("ar2_stall", 32'(link_arvalid), 0);
        check("ar2_stall_rdy", 32'(user_arready), 0);
        check("rd_cnt_2", 32'(rd_ostd_cnt), 2);
        link_rvalid = 1; link_rlast = 1; user_rready = 1;
        #1 check("ar2_stall_during_r", 32'(link_arvalid), 0);
        nxt();
        link_rvalid = 0; link_rlast = 0; user_rready = 0;
        #1 check("ar2_issue_after_r", 32'(link_arvalid), 1);
        check("rd_cnt_after_r", 32'(rd_ostd_cnt), 1);
        nxt();
        user_arvalid = 0;
        #1 check("rd_cnt_3rd", 32'(rd_ostd_cnt), 2);

        // R-last brings count to 1, then AR and R-last in the same cycle.
        link_rvalid = 1; link_rlast = 1; user_rready = 1;
        nxt();
        user_arvalid = 1;
        #1 check("simul_ar_valid", 32'(link_arvalid), 1);
        nxt();
        user_arvalid = 0; link_rvalid = 0; link_rlast = 0; user_rready = 0;
        #1 check("simul_rd_cnt", 32'(rd_ostd_cnt), 1);

        // B with nothing outstanding.
        link_bvalid = 1; user_bready = 1;
        nxt();
        link_bvalid = 0; user_bready = 0;
        #1 check("b_ufl_err", 32'(err_status), 32'b010);
        check("b_ufl_wr_cnt", 32'(wr_ostd_cnt), 0);

        // AW and W together: W waits one cycle, 4-beat burst returns credit.
        link_awready = 1; link_wready = 1; user_awvalid = 1; user_wvalid = 1;
        #1 check("aw_first", 32'(link_awvalid), 1);
        check("w_held", 32'(link_wvalid), 0);
        nxt();
        user_awvalid = 0;
        for (int b = 0; b < 4; b++) begin
            user_wlast = (b == 3);
            #1 check($sformatf("w_beat%0d", b), 32'(link_wvalid), 1);
            nxt();
        end
        user_wlast = 0;
        #1 check("wcred_zero", 32'(link_wvalid), 0);
        check("wr_cnt_after_w", 32'(wr_ostd_cnt), 1);
        user_wvalid = 0;

        // Retire that write, then one AW whose W is held back; one more AR.
        link_bvalid = 1; user_bready = 1;
        nxt();
        link_bvalid = 0; user_bready = 0;
        user_awvalid = 1; user_arvalid = 1;
        nxt();
        user_awvalid = 0; user_arvalid = 0;
        #1 check("pre_drain_rd", 32'(rd_ostd_cnt), 2);
        check("pre_drain_wr", 32'(wr_ostd_cnt), 1);

        // Drain: AR/AW blocked, W and completions still flow.
        drain_req = 1;
        nxt();
        user_arvalid = 1; user_awvalid = 1;
        user_wvalid = 1; user_wlast = 1;
        #1 check("drain_ar_blk", 32'(link_arvalid), 0);
        check("drain_aw_blk", 32'(link_awvalid), 0);
        check("drain_w_flows", 32'(link_wvalid), 1);
        nxt();
        user_wvalid = 0; user_wlast = 0;
        link_rvalid = 1; link_rlast = 1; user_rready = 1;
        nxt();
        nxt();
        link_rvalid = 0; link_rlast = 0; user_rready = 0;
        link_bvalid = 1; user_bready = 1;
        #1 check("ack_before_last", 32'(drain_ack), 0);
        nxt();
        link_bvalid = 0; user_bready = 0;
        #1 check("drained_rd", 32'(rd_ostd_cnt), 0);
        check("drained_wr", 32'(wr_ostd_cnt), 0);
        check("ack_not_early", 32'(drain_ack), 0);
        nxt();
        check("drain_ack", 32'(drain_ack), 1);
        check("quiesced_ar_blk", 32'(link_arvalid), 0);

        // Release drain: issue resumes.
        drain_req = 0;
        nxt();
        check("resume_ack_low", 32'(drain_ack), 0);
        check("resume_ar", 32'(link_arvalid), 1);
        check("resume_aw", 32'(link_awvalid), 1);
        nxt();
        user_arvalid = 0; user_awvalid = 0;
        #1 check("resume_rd_cnt", 32'(rd_ostd_cnt), 1);
        check("resume_wr_cnt", 32'(wr_ostd_cnt), 1);

        // Long idle with a read outstanding: no watchdog error within 40 cycles.
        repeat (40) nxt();
        check("no_wdog", 32'(err_status), 32'b010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
